// File: rtl/fe_fifo_packer_if.sv
// Event-stream and capture-FIFO signals shared between the front-end capture FSM,
// the packer and the capture FIFO.
`ifndef FE_FIFO_CMD_TIME
`define FE_FIFO_CMD_TIME 2'b11
`endif

interface fe_fifo_packer_if #(
    parameter int pTIMESTAMP_FULL_WIDTH = 16,
    parameter int pDATA_WIDTH           = 8,
    parameter int pW                    = 18
);
    logic                             I_wr;
    logic [1:0]                       I_command;
    logic [pTIMESTAMP_FULL_WIDTH-1:0] I_time;
    logic [pDATA_WIDTH-1:0]           I_data;
    logic                             I_fifo_full;
    logic [pW-1:0]                    O_fifo_din;
    logic                             O_fifo_wr;

    // master: capture FSM plus FIFO side; slave: the packer itself
    modport master (
        output I_wr, I_command, I_time, I_data, I_fifo_full,
        input  O_fifo_din, O_fifo_wr
    );

    modport slave (
        input  I_wr, I_command, I_time, I_data, I_fifo_full,
        output O_fifo_din, O_fifo_wr
    );
endinterface

// File: rtl/fe_fifo_packer.sv
// Packs capture events into FIFO words and feeds the capture FIFO through a
// 2-entry skid buffer, tracking drops, timestamp clipping and written words.
`ifndef FE_FIFO_CMD_TIME
`define FE_FIFO_CMD_TIME 2'b11
`endif

module fe_fifo_packer #(
    parameter int pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int pDATA_WIDTH            = 8,
    parameter int pDROP_CTR_WIDTH        = 16,
    parameter int pCOUNT_WIDTH           = 24
) (
    input  logic                       fe_clk,
    input  logic                       reset_i,
    fe_fifo_packer_if.slave            bus,
    input  logic                       I_flush,
    output logic                       O_overflow,
    output logic                       O_ts_clipped,
    output logic [pDROP_CTR_WIDTH-1:0] O_drop_count,
    output logic [pCOUNT_WIDTH-1:0]    O_word_count,
    output logic                       O_empty
);
    localparam int pSHORT_PAYLOAD = pTIMESTAMP_SHORT_WIDTH + pDATA_WIDTH;
    localparam int pPAYLOAD = (pTIMESTAMP_FULL_WIDTH > pSHORT_PAYLOAD) ?
                              pTIMESTAMP_FULL_WIDTH : pSHORT_PAYLOAD;
    localparam int pW = 2 + pPAYLOAD;
    localparam logic [pTIMESTAMP_FULL_WIDTH-1:0] TS_SHORT_MAX =
        pTIMESTAMP_FULL_WIDTH'((1 << pTIMESTAMP_SHORT_WIDTH) - 1);

    logic [pW-1:0] mem [2];
    logic          head;
    logic [1:0]    count;
    logic          tail;
    logic          pop;
    logic          push;
    logic          drop;
    logic [pW-1:0] packed_word;
    logic          clip;

    // Data words carry a short timestamp that saturates rather than wraps
    always_comb begin
        packed_word = '0;
        clip        = 1'b0;
        packed_word[pW-1 -: 2] = bus.I_command;
        if (bus.I_command == `FE_FIFO_CMD_TIME) begin
            packed_word[pTIMESTAMP_FULL_WIDTH-1:0] = bus.I_time;
        end else begin
            if (bus.I_time > TS_SHORT_MAX) begin
                packed_word[pW-3 -: pTIMESTAMP_SHORT_WIDTH] = '1;
                clip = 1'b1;
            end else begin
                packed_word[pW-3 -: pTIMESTAMP_SHORT_WIDTH] =
                    bus.I_time[pTIMESTAMP_SHORT_WIDTH-1:0];
            end
            packed_word[pW-3-pTIMESTAMP_SHORT_WIDTH -: pDATA_WIDTH] = bus.I_data;
        end
    end

    // A pop frees the head slot in the same cycle, so a full buffer can still accept
    assign tail = head ^ count[0];
    assign pop  = (count != 2'd0) && !bus.I_fifo_full && !I_flush;
    assign push = bus.I_wr && ((count != 2'd2) || pop) && !I_flush;
    assign drop = bus.I_wr && !push && !I_flush;

    assign bus.O_fifo_wr  = pop;
    assign bus.O_fifo_din = mem[head];
    assign O_empty        = (count == 2'd0);

    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            mem[0]       <= '0;
            mem[1]       <= '0;
            head         <= 1'b0;
            count        <= 2'd0;
            O_overflow   <= 1'b0;
            O_ts_clipped <= 1'b0;
            O_drop_count <= '0;
            O_word_count <= '0;
        end else if (I_flush) begin
            mem[0]       <= '0;
            mem[1]       <= '0;
            head         <= 1'b0;
            count        <= 2'd0;
            O_overflow   <= 1'b0;
            O_ts_clipped <= 1'b0;
            O_drop_count <= '0;
            O_word_count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= packed_word;
                if (clip) begin
                    O_ts_clipped <= 1'b1;
                end
            end
            if (pop) begin
                head <= ~head;
                if (O_word_count != '1) begin
                    O_word_count <= O_word_count + 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (drop) begin
                O_overflow <= 1'b1;
                if (O_drop_count != '1) begin
                    O_drop_count <= O_drop_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fe_fifo_packer.sv
// Directed scenarios plus a randomized run against a queue-based model of the
// packer's event-to-word behaviour.
`ifndef FE_FIFO_CMD_TIME
`define FE_FIFO_CMD_TIME 2'b11
`endif

module tb_fe_fifo_packer;
    localparam logic [1:0] CMD_TIME = `FE_FIFO_CMD_TIME;

    logic        fe_clk;
    logic        reset_i;
    logic        I_flush;
    logic        O_overflow;
    logic        O_ts_clipped;
    logic [15:0] O_drop_count;
    logic [23:0] O_word_count;
    logic        O_empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] model_q [$];
    int          exp_drops;
    int          exp_words;
    logic        exp_ovf;
    logic        exp_clip;

    fe_fifo_packer_if bus ();

    fe_fifo_packer dut (
        .fe_clk       (fe_clk),
        .reset_i      (reset_i),
        .bus          (bus.slave),
        .I_flush      (I_flush),
        .O_overflow   (O_overflow),
        .O_ts_clipped (O_ts_clipped),
        .O_drop_count (O_drop_count),
        .O_word_count (O_word_count),
        .O_empty      (O_empty)
    );

    initial fe_clk = 1'b0;
    always #5 fe_clk = ~fe_clk;

    function automatic logic [17:0] pack(input logic [1:0] cmd, input logic [15:0] tm,
                                         input logic [7:0] dat);
        if (cmd == CMD_TIME) return {cmd, tm};
        return {cmd, (tm > 16'd7) ? 3'b111 : tm[2:0], dat, 5'b00000};
    endfunction

    task automatic drive(input logic wr, input logic [1:0] cmd, input logic [15:0] tm,
                         input logic [7:0] dat, input logic full, input logic flush);
        @(negedge fe_clk);
        bus.I_wr        = wr;
        bus.I_command   = cmd;
        bus.I_time      = tm;
        bus.I_data      = dat;
        bus.I_fifo_full = full;
        I_flush         = flush;
        #1;
    endtask

    task automatic idle(input logic full);
        drive(1'b0, 2'd0, 16'd0, 8'd0, full, 1'b0);
    endtask

    task automatic flush_cycle();
        drive(1'b0, 2'd0, 16'd0, 8'd0, 1'b0, 1'b1);
    endtask

    // Model: a queue of at most two words, popped whenever the FIFO accepts
    task automatic model_step(input logic wr, input logic [1:0] cmd, input logic [15:0] tm,
                              input logic [7:0] dat, input logic full, input logic flush);
        int  sz;
        bit  p;
        if (flush) begin
            model_q.delete();
            exp_drops = 0;
            exp_words = 0;
            exp_ovf   = 1'b0;
            exp_clip  = 1'b0;
            return;
        end
        sz = model_q.size();
        p  = (sz != 0) && !full;
        if (p) begin
            void'(model_q.pop_front());
            if (exp_words < 24'hFFFFFF) exp_words++;
        end
        if (wr) begin
            if (sz < 2 || p) begin
                model_q.push_back(pack(cmd, tm, dat));
                if (cmd != CMD_TIME && tm > 16'd7) exp_clip = 1'b1;
            end else begin
                exp_ovf = 1'b1;
                if (exp_drops < 16'hFFFF) exp_drops++;
            end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        bus.I_wr = 1'b0; bus.I_command = 2'd0; bus.I_time = 16'd0; bus.I_data = 8'd0;
        bus.I_fifo_full = 1'b0; I_flush = 1'b0;
        idle(1'b0);
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b0 || bus.O_fifo_din !== 18'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_fifo: wr=%b din=%h required wr=0 din=0",
                     bus.O_fifo_wr, bus.O_fifo_din);
        end
        n_checks++;
        if (O_overflow !== 1'b0 || O_ts_clipped !== 1'b0 || O_empty !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: ovf=%b clip=%b empty=%b required 0 0 1",
                     O_overflow, O_ts_clipped, O_empty);
        end
        n_checks++;
        if (O_drop_count !== 16'd0 || O_word_count !== 24'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_counts: drops=%0d words=%0d required 0 0",
                     O_drop_count, O_word_count);
        end
        @(negedge fe_clk);
        reset_i = 1'b0;
    endtask

    task automatic test_data_event();
        flush_cycle();
        drive(1'b1, 2'd0, 16'd5, 8'hA5, 1'b0, 1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL data_no_bypass: wr=%b required 0", bus.O_fifo_wr);
        end
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b1 || bus.O_fifo_din !== 18'h0B4A0) begin
            n_fail++;
            $display("[TB] FAIL data_word: wr=%b din=%h required wr=1 din=0b4a0",
                     bus.O_fifo_wr, bus.O_fifo_din);
        end
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b0 || O_word_count !== 24'd1 || O_empty !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL data_after: wr=%b words=%0d empty=%b required 0 1 1",
                     bus.O_fifo_wr, O_word_count, O_empty);
        end
    endtask

    task automatic test_time_event();
        flush_cycle();
        drive(1'b1, CMD_TIME, 16'h1234, 8'hFF, 1'b0, 1'b0);
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b1 || bus.O_fifo_din !== {CMD_TIME, 16'h1234}) begin
            n_fail++;
            $display("[TB] FAIL time_word: wr=%b din=%h required wr=1 din=%h",
                     bus.O_fifo_wr, bus.O_fifo_din, {CMD_TIME, 16'h1234});
        end
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b0 || O_word_count !== 24'd1 || O_ts_clipped !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL time_after: wr=%b words=%0d clip=%b required 0 1 0",
                     bus.O_fifo_wr, O_word_count, O_ts_clipped);
        end
    endtask

    task automatic test_ts_clip();
        flush_cycle();
        drive(1'b1, 2'd0, 16'd7, 8'h5A, 1'b0, 1'b0);
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_din !== {2'b00, 3'b111, 8'h5A, 5'd0} || O_ts_clipped !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ts_edge7: din=%h clip=%b required din=%h clip=0",
                     bus.O_fifo_din, O_ts_clipped, {2'b00, 3'b111, 8'h5A, 5'd0});
        end
        drive(1'b1, 2'd1, 16'd9, 8'h3C, 1'b0, 1'b0);
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b1 || bus.O_fifo_din !== {2'b01, 3'b111, 8'h3C, 5'd0}
            || O_ts_clipped !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ts_clip9: wr=%b din=%h clip=%b required wr=1 din=%h clip=1",
                     bus.O_fifo_wr, bus.O_fifo_din, O_ts_clipped, {2'b01, 3'b111, 8'h3C, 5'd0});
        end
        for (int i = 0; i < 3; i++) idle(1'b0);
        n_checks++;
        if (O_ts_clipped !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ts_sticky: clip=%b required 1", O_ts_clipped);
        end
        flush_cycle();
        idle(1'b0);
        n_checks++;
        if (O_ts_clipped !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ts_flush_clear: clip=%b required 0", O_ts_clipped);
        end
    endtask

    task automatic test_full_drop();
        flush_cycle();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'd0, 16'(i), 8'(8'h10 + i), 1'b1, 1'b0);
            n_checks++;
            if (bus.O_fifo_wr !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL full_no_write: event %0d wr=%b required 0", i, bus.O_fifo_wr);
            end
        end
        idle(1'b1);
        n_checks++;
        if (O_drop_count !== 16'd2 || O_overflow !== 1'b1 || O_empty !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_drops: drops=%0d ovf=%b empty=%b required 2 1 0",
                     O_drop_count, O_overflow, O_empty);
        end
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b1 || bus.O_fifo_din !== pack(2'd0, 16'd1, 8'h11)) begin
            n_fail++;
            $display("[TB] FAIL full_first: wr=%b din=%h required wr=1 din=%h",
                     bus.O_fifo_wr, bus.O_fifo_din, pack(2'd0, 16'd1, 8'h11));
        end
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b1 || bus.O_fifo_din !== pack(2'd0, 16'd2, 8'h12)) begin
            n_fail++;
            $display("[TB] FAIL full_second: wr=%b din=%h required wr=1 din=%h",
                     bus.O_fifo_wr, bus.O_fifo_din, pack(2'd0, 16'd2, 8'h12));
        end
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b0 || O_empty !== 1'b1 || O_word_count !== 24'd2) begin
            n_fail++;
            $display("[TB] FAIL full_drain: wr=%b empty=%b words=%0d required 0 1 2",
                     bus.O_fifo_wr, O_empty, O_word_count);
        end
    endtask

    task automatic test_back_to_back();
        flush_cycle();
        drive(1'b1, 2'd0, 16'd1, 8'h11, 1'b1, 1'b0);
        drive(1'b1, 2'd1, 16'd2, 8'h22, 1'b1, 1'b0);
        drive(1'b1, CMD_TIME, 16'hBEEF, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b1 || bus.O_fifo_din !== pack(2'd0, 16'd1, 8'h11)) begin
            n_fail++;
            $display("[TB] FAIL b2b_pop: wr=%b din=%h required wr=1 din=%h",
                     bus.O_fifo_wr, bus.O_fifo_din, pack(2'd0, 16'd1, 8'h11));
        end
        idle(1'b1);
        n_checks++;
        if (O_empty !== 1'b0 || O_drop_count !== 16'd0 || O_overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_accept: empty=%b drops=%0d ovf=%b required 0 0 0",
                     O_empty, O_drop_count, O_overflow);
        end
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b1 || bus.O_fifo_din !== pack(2'd1, 16'd2, 8'h22)) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: wr=%b din=%h required wr=1 din=%h",
                     bus.O_fifo_wr, bus.O_fifo_din, pack(2'd1, 16'd2, 8'h22));
        end
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b1 || bus.O_fifo_din !== {CMD_TIME, 16'hBEEF}) begin
            n_fail++;
            $display("[TB] FAIL b2b_third: wr=%b din=%h required wr=1 din=%h",
                     bus.O_fifo_wr, bus.O_fifo_din, {CMD_TIME, 16'hBEEF});
        end
        idle(1'b0);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b0 || O_empty !== 1'b1 || O_word_count !== 24'd3) begin
            n_fail++;
            $display("[TB] FAIL b2b_drain: wr=%b empty=%b words=%0d required 0 1 3",
                     bus.O_fifo_wr, O_empty, O_word_count);
        end
    endtask

    task automatic test_flush();
        flush_cycle();
        drive(1'b1, 2'd0, 16'd3, 8'h01, 1'b1, 1'b0);
        drive(1'b1, 2'd0, 16'd20, 8'h02, 1'b1, 1'b0);
        drive(1'b1, 2'd0, 16'd4, 8'h03, 1'b1, 1'b0);
        drive(1'b1, 2'd0, 16'd5, 8'h04, 1'b0, 1'b1);
        n_checks++;
        if (bus.O_fifo_wr !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_wr: wr=%b required 0", bus.O_fifo_wr);
        end
        idle(1'b0);
        n_checks++;
        if (O_empty !== 1'b1 || bus.O_fifo_wr !== 1'b0 || O_overflow !== 1'b0
            || O_ts_clipped !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_state: empty=%b wr=%b ovf=%b clip=%b required 1 0 0 0",
                     O_empty, bus.O_fifo_wr, O_overflow, O_ts_clipped);
        end
        n_checks++;
        if (O_drop_count !== 16'd0 || O_word_count !== 24'd0) begin
            n_fail++;
            $display("[TB] FAIL flush_counts: drops=%0d words=%0d required 0 0",
                     O_drop_count, O_word_count);
        end
    endtask

    task automatic test_reset_mid_burst();
        flush_cycle();
        drive(1'b1, 2'd0, 16'd1, 8'hC1, 1'b1, 1'b0);
        drive(1'b1, 2'd0, 16'd2, 8'hC2, 1'b1, 1'b0);
        idle(1'b0);
        reset_i = 1'b1;
        #1;
        n_checks++;
        if (bus.O_fifo_wr !== 1'b0 || O_empty !== 1'b1 || bus.O_fifo_din !== 18'd0
            || O_word_count !== 24'd0) begin
            n_fail++;
            $display("[TB] FAIL midreset_now: wr=%b empty=%b din=%h words=%0d required 0 1 0 0",
                     bus.O_fifo_wr, O_empty, bus.O_fifo_din, O_word_count);
        end
        @(negedge fe_clk);
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            n_checks++;
            if (bus.O_fifo_wr !== 1'b0 || O_word_count !== 24'd0) begin
                n_fail++;
                $display("[TB] FAIL midreset_after: cycle %0d wr=%b words=%0d required 0 0",
                         i, bus.O_fifo_wr, O_word_count);
            end
        end
    endtask

    task automatic test_random();
        logic        wr, full, flush;
        logic [1:0]  cmd;
        logic [15:0] tm;
        logic [7:0]  dat;
        logic        exp_wr;
        flush_cycle();
        model_step(1'b0, 2'd0, 16'd0, 8'd0, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            wr    = ($urandom_range(99, 0) < 70);
            cmd   = 2'($urandom_range(3, 0));
            tm    = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(15, 0)) : 16'($urandom);
            dat   = 8'($urandom);
            full  = ($urandom_range(99, 0) < 35);
            flush = ($urandom_range(99, 0) < 2);
            drive(wr, cmd, tm, dat, full, flush);
            exp_wr = (model_q.size() != 0) && !full && !flush;
            n_checks++;
            if (bus.O_fifo_wr !== exp_wr) begin
                n_fail++;
                $display("[TB] FAIL rnd_wr: cycle %0d wr=%b required %b", cyc, bus.O_fifo_wr, exp_wr);
            end
            if (exp_wr) begin
                n_checks++;
                if (bus.O_fifo_din !== model_q[0]) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_din: cycle %0d din=%h required %h",
                             cyc, bus.O_fifo_din, model_q[0]);
                end
            end
            n_checks++;
            if (O_empty !== (model_q.size() == 0) || O_overflow !== exp_ovf
                || O_ts_clipped !== exp_clip) begin
                n_fail++;
                $display("[TB] FAIL rnd_flags: cycle %0d empty=%b ovf=%b clip=%b required %b %b %b",
                         cyc, O_empty, O_overflow, O_ts_clipped,
                         (model_q.size() == 0), exp_ovf, exp_clip);
            end
            n_checks++;
            if (O_drop_count !== 16'(exp_drops) || O_word_count !== 24'(exp_words)) begin
                n_fail++;
                $display("[TB] FAIL rnd_counts: cycle %0d drops=%0d words=%0d required %0d %0d",
                         cyc, O_drop_count, O_word_count, exp_drops, exp_words);
            end
            model_step(wr, cmd, tm, dat, full, flush);
        end
    endtask

    initial begin
        test_reset();
        test_data_event();
        test_time_event();
        test_ts_clip();
        test_full_drop();
        test_back_to_back();
        test_flush();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
